// File: rtl/wishbone_bus_if_pkg.sv
// Shared bus widths, zero word and FSM encodings for the CPU-side Wishbone master.
package wishbone_bus_if_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;
    localparam int CNT_W     = 8;

    typedef logic [WB_ADDR_W-1:0] wishbone_addr_bus_t;
    typedef logic [WB_DATA_W-1:0] wishbone_data_bus_t;
    typedef logic [WB_SEL_W-1:0]  wishbone_sel_bus_t;
    typedef logic [CNT_W-1:0]     timeout_cnt_t;

    localparam wishbone_data_bus_t ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_BUSY       = 2'd1,
        ST_WAIT_STALL = 2'd2
    } wb_state_t;

    // Saturates at all-ones so a stuck slave can never wrap the count.
    function automatic timeout_cnt_t sat_inc(input timeout_cnt_t cnt);
        return (cnt == '1) ? cnt : cnt + timeout_cnt_t'(1);
    endfunction

endpackage

// File: rtl/wishbone_bus_if.sv
// Single-transaction Wishbone master between the CPU memory stage and the bus,
// with read-data hold across pipeline stalls and a BUSY timeout abort.
module wishbone_bus_if
    import wishbone_bus_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               cpu_ce_i,
    input  logic               cpu_we_i,
    input  wishbone_sel_bus_t  cpu_sel_i,
    input  wishbone_addr_bus_t cpu_addr_i,
    input  wishbone_data_bus_t cpu_data_i,
    output wishbone_data_bus_t cpu_data_o,

    input  logic               stall_i,
    input  logic               flush_i,
    output logic               stallreq_o,
    output logic               bus_err_o,

    output wishbone_addr_bus_t wishbone_addr_o,
    output wishbone_data_bus_t wishbone_data_o,
    output logic               wishbone_we_o,
    output wishbone_sel_bus_t  wishbone_sel_o,
    output logic               wishbone_stb_o,
    output logic               wishbone_cyc_o,
    input  wishbone_data_bus_t wishbone_data_i,
    input  logic               wishbone_ack_i,

    output wb_state_t          dbg_state
);

    localparam timeout_cnt_t TIMEOUT_LAST = timeout_cnt_t'(TIMEOUT_CYCLES - 1);

    wb_state_t          state;
    wb_state_t          state_nxt;
    timeout_cnt_t       cnt;
    wishbone_data_bus_t rd_buf;
    logic               cyc_q;
    logic               timeout_now;
    logic               start_req;

    // Handshake: the CPU request (cpu_ce_i) is accepted in IDLE only and is
    // held off with stallreq_o until the slave asserts wishbone_ack_i while
    // cyc/stb are high; one ack completes exactly one transaction.
    assign start_req   = cpu_ce_i && !flush_i;
    assign timeout_now = (state == ST_BUSY) && !flush_i && !wishbone_ack_i
                         && (cnt == TIMEOUT_LAST);

    always_comb begin
        state_nxt  = state;
        stallreq_o = 1'b0;
        cpu_data_o = ZERO_WORD;
        bus_err_o  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    stallreq_o = 1'b1;
                    state_nxt  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stallreq_o = !wishbone_ack_i && !timeout_now;
                if (flush_i) begin
                    state_nxt = ST_IDLE;
                end else if (wishbone_ack_i) begin
                    if (!wishbone_we_o) begin
                        cpu_data_o = wishbone_data_i;
                    end
                    state_nxt = stall_i ? ST_WAIT_STALL : ST_IDLE;
                end else if (timeout_now) begin
                    bus_err_o = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_STALL: begin
                cpu_data_o = rd_buf;
                if (flush_i || !stall_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus request registers; cyc and stb share one flop so they cannot diverge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wishbone_addr_o <= '0;
            wishbone_data_o <= ZERO_WORD;
            wishbone_we_o   <= 1'b0;
            wishbone_sel_o  <= '0;
            cyc_q           <= 1'b0;
            cnt             <= '0;
            rd_buf          <= ZERO_WORD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        wishbone_addr_o <= cpu_addr_i;
                        wishbone_data_o <= cpu_data_i;
                        wishbone_we_o   <= cpu_we_i;
                        wishbone_sel_o  <= cpu_sel_i;
                        cyc_q           <= 1'b1;
                        cnt             <= '0;
                    end
                end
                ST_BUSY: begin
                    if (flush_i || wishbone_ack_i || timeout_now) begin
                        cyc_q          <= 1'b0;
                        wishbone_we_o  <= 1'b0;
                        wishbone_sel_o <= '0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                    // A late ack under flush must not leak into rd_buf.
                    if (flush_i) begin
                        rd_buf <= ZERO_WORD;
                    end else if (wishbone_ack_i) begin
                        rd_buf <= wishbone_we_o ? ZERO_WORD : wishbone_data_i;
                    end
                end
                ST_WAIT_STALL: begin
                    if (flush_i) begin
                        rd_buf <= ZERO_WORD;
                    end
                end
                default: begin
                    cyc_q <= 1'b0;
                end
            endcase
        end
    end

    assign wishbone_cyc_o = cyc_q;
    assign wishbone_stb_o = cyc_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Directed bench for wishbone_bus_if: reads, byte-lane write, back-to-back,
// stall hold, timeout, flush and asynchronous reset.
module tb_wishbone_bus_if;
    import wishbone_bus_if_pkg::*;

    logic        clk;
    logic        rst;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stall_i;
    logic        flush_i;
    logic        stallreq_o;
    logic        bus_err_o;
    logic [31:0] wishbone_addr_o;
    logic [31:0] wishbone_data_o;
    logic        wishbone_we_o;
    logic [3:0]  wishbone_sel_o;
    logic        wishbone_stb_o;
    logic        wishbone_cyc_o;
    logic [31:0] wishbone_data_i;
    logic        wishbone_ack_i;
    wb_state_t   dbg_state;

    int checks = 0;
    int errors = 0;

    wishbone_bus_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_ce_i        (cpu_ce_i),
        .cpu_we_i        (cpu_we_i),
        .cpu_sel_i       (cpu_sel_i),
        .cpu_addr_i      (cpu_addr_i),
        .cpu_data_i      (cpu_data_i),
        .cpu_data_o      (cpu_data_o),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .stallreq_o      (stallreq_o),
        .bus_err_o       (bus_err_o),
        .wishbone_addr_o (wishbone_addr_o),
        .wishbone_data_o (wishbone_data_o),
        .wishbone_we_o   (wishbone_we_o),
        .wishbone_sel_o  (wishbone_sel_o),
        .wishbone_stb_o  (wishbone_stb_o),
        .wishbone_cyc_o  (wishbone_cyc_o),
        .wishbone_data_i (wishbone_data_i),
        .wishbone_ack_i  (wishbone_ack_i),
        .dbg_state       (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // slave model: word memory, byte lanes, programmable ack latency
    logic [31:0] mem [0:15];
    logic        ack_en;
    int          lat;
    int          wait_cnt;
    int          ack_count;
    int          err_pulses;
    logic        pl_en;
    logic [3:0]  pl_idx;
    logic [31:0] pl_val;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            wishbone_ack_i  <= 1'b0;
            wishbone_data_i <= 32'h0;
            wait_cnt        <= 0;
        end else begin
            if (pl_en) mem[pl_idx] <= pl_val;
            if (wishbone_cyc_o && wishbone_stb_o && !wishbone_ack_i && ack_en) begin
                if (wait_cnt + 1 >= lat) begin
                    wishbone_ack_i  <= 1'b1;
                    wishbone_data_i <= mem[wishbone_addr_o[5:2]];
                    ack_count       <= ack_count + 1;
                    wait_cnt        <= 0;
                    if (wishbone_we_o) begin
                        for (int b = 0; b < 4; b++)
                            if (wishbone_sel_o[b])
                                mem[wishbone_addr_o[5:2]][8*b +: 8] <= wishbone_data_o[8*b +: 8];
                    end
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end else begin
                wishbone_ack_i <= 1'b0;
                if (!(wishbone_cyc_o && wishbone_stb_o)) wait_cnt <= 0;
            end
        end
    end

    always @(posedge clk) begin
        if (bus_err_o) err_pulses <= err_pulses + 1;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        tick();
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        tick();
        pl_en  = 1'b0;
    endtask

    task automatic request(input logic we, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] data);
        cpu_ce_i   = 1'b1;
        cpu_we_i   = we;
        cpu_sel_i  = sel;
        cpu_addr_i = addr;
        cpu_data_i = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    int acks_before;
    int errs_before;

    initial begin
        rst = 1'b1;
        cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_sel_i = 4'h0;
        cpu_addr_i = 32'h0; cpu_data_i = 32'h0;
        stall_i = 1'b0; flush_i = 1'b0;
        ack_en = 1'b1; lat = 1; ack_count = 0; err_pulses = 0;
        pl_en = 1'b0; pl_idx = 4'h0; pl_val = 32'h0;

        // reset state
        repeat (2) @(posedge clk);
        mid();
        chk("rst_cyc", 32'(wishbone_cyc_o), 32'h0);
        chk("rst_stb", 32'(wishbone_stb_o), 32'h0);
        chk("rst_bus_err", 32'(bus_err_o), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        rst = 1'b0;

        preload(4'd4, 32'hDEADBEEF);
        preload(4'd12, 32'hCAFE0001);

        // single read of 0x10
        tick();
        request(1'b0, 4'hF, 32'h0000_0010, 32'h0);
        mid();
        chk("rd_idle_stallreq", 32'(stallreq_o), 32'h1);
        chk("rd_idle_stb", 32'(wishbone_stb_o), 32'h0);
        tick();
        cpu_ce_i = 1'b0;
        cpu_addr_i = 32'hBAD0_0000;
        mid();
        chk("rd_busy_stb", 32'(wishbone_stb_o), 32'h1);
        chk("rd_busy_addr_held", wishbone_addr_o, 32'h0000_0010);
        chk("rd_busy_stallreq", 32'(stallreq_o), 32'h1);
        chk("rd_busy_data_zero", cpu_data_o, 32'h0);
        tick();
        mid();
        chk("rd_ack_data", cpu_data_o, 32'hDEADBEEF);
        chk("rd_ack_stallreq", 32'(stallreq_o), 32'h0);
        tick();
        mid();
        chk("rd_after_stb", 32'(wishbone_stb_o), 32'h0);
        chk("rd_after_data", cpu_data_o, 32'h0);
        chk("rd_after_state", 32'(dbg_state), 32'(ST_IDLE));

        // byte-lane write of 0x20
        tick();
        request(1'b1, 4'b0011, 32'h0000_0020, 32'h1234_5678);
        tick();
        cpu_ce_i = 1'b0;
        mid();
        chk("wr_we", 32'(wishbone_we_o), 32'h1);
        chk("wr_sel", 32'(wishbone_sel_o), 32'h3);
        chk("wr_data", wishbone_data_o, 32'h1234_5678);
        tick();
        mid();
        chk("wr_ack_data_zero", cpu_data_o, 32'h0);
        chk("wr_ack_stallreq", 32'(stallreq_o), 32'h0);
        tick();
        mid();
        chk("wr_after_we", 32'(wishbone_we_o), 32'h0);
        chk("wr_after_sel", 32'(wishbone_sel_o), 32'h0);

        // back-to-back reads, ce held high
        acks_before = ack_count;
        tick();
        request(1'b0, 4'hF, 32'h0000_0010, 32'h0);
        tick();
        mid();
        chk("b2b_first_stb", 32'(wishbone_stb_o), 32'h1);
        tick();
        mid();
        chk("b2b_first_data", cpu_data_o, 32'hDEADBEEF);
        cpu_addr_i = 32'h0000_0020;
        tick();
        mid();
        chk("b2b_gap_stb", 32'(wishbone_stb_o), 32'h0);
        tick();
        mid();
        chk("b2b_second_stb", 32'(wishbone_stb_o), 32'h1);
        chk("b2b_second_addr", wishbone_addr_o, 32'h0000_0020);
        cpu_ce_i = 1'b0;
        tick();
        mid();
        chk("b2b_second_data", cpu_data_o, 32'h0000_5678);
        tick();
        mid();
        chk("b2b_ack_count", 32'(ack_count - acks_before), 32'd2);
        chk("b2b_end_stb", 32'(wishbone_stb_o), 32'h0);

        // stall after ack
        tick();
        request(1'b0, 4'hF, 32'h0000_0030, 32'h0);
        tick();
        cpu_ce_i = 1'b0;
        tick();
        mid();
        chk("st_ack_data", cpu_data_o, 32'hCAFE0001);
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            mid();
            chk("st_wait_state", 32'(dbg_state), 32'(ST_WAIT_STALL));
            chk("st_wait_data", cpu_data_o, 32'hCAFE0001);
            chk("st_wait_stallreq", 32'(stallreq_o), 32'h0);
        end
        stall_i = 1'b0;
        tick();
        mid();
        chk("st_end_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("st_end_data", cpu_data_o, 32'h0);

        // timeout with the slave never acking
        ack_en = 1'b0;
        errs_before = err_pulses;
        tick();
        request(1'b0, 4'hF, 32'h0000_0010, 32'h0);
        tick();
        cpu_ce_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            mid();
            chk("to_early_bus_err", 32'(bus_err_o), 32'h0);
            tick();
        end
        mid();
        chk("to_4th_bus_err", 32'(bus_err_o), 32'h1);
        chk("to_4th_stallreq", 32'(stallreq_o), 32'h0);
        chk("to_4th_data", cpu_data_o, 32'h0);
        tick();
        mid();
        chk("to_after_cyc", 32'(wishbone_cyc_o), 32'h0);
        chk("to_after_bus_err", 32'(bus_err_o), 32'h0);
        tick();
        chk("to_pulse_count", 32'(err_pulses - errs_before), 32'd1);
        ack_en = 1'b1;

        // flush in the second BUSY cycle
        lat = 10;
        request(1'b0, 4'hF, 32'h0000_0010, 32'h0);
        tick();
        cpu_ce_i = 1'b0;
        tick();
        flush_i = 1'b1;
        mid();
        chk("fl_busy_cyc", 32'(wishbone_cyc_o), 32'h1);
        tick();
        flush_i = 1'b0;
        mid();
        chk("fl_after_cyc", 32'(wishbone_cyc_o), 32'h0);
        chk("fl_after_state", 32'(dbg_state), 32'(ST_IDLE));

        // flush beats ack in the same cycle
        lat = 1;
        tick();
        request(1'b0, 4'hF, 32'h0000_0010, 32'h0);
        tick();
        cpu_ce_i = 1'b0;
        tick();
        flush_i = 1'b1;
        stall_i = 1'b1;
        mid();
        chk("fla_ack_seen", 32'(wishbone_ack_i), 32'h1);
        chk("fla_data_zero", cpu_data_o, 32'h0);
        tick();
        flush_i = 1'b0;
        mid();
        chk("fla_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        chk("fla_cyc", 32'(wishbone_cyc_o), 32'h0);
        stall_i = 1'b0;

        // asynchronous reset mid-BUSY
        lat = 10;
        tick();
        request(1'b0, 4'hF, 32'h0000_0010, 32'h0);
        tick();
        cpu_ce_i = 1'b0;
        mid();
        chk("ar_busy_cyc", 32'(wishbone_cyc_o), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_cyc_immediate", 32'(wishbone_cyc_o), 32'h0);
        chk("ar_stb_immediate", 32'(wishbone_stb_o), 32'h0);
        chk("ar_state_immediate", 32'(dbg_state), 32'(ST_IDLE));
        mid();
        rst = 1'b0;
        tick();
        mid();
        chk("ar_after_cyc", 32'(wishbone_cyc_o), 32'h0);
        chk("ar_after_data", cpu_data_o, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
